// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART packet bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } tx_state_t;

  localparam int DROP_CNT_W = 8;

  localparam logic [7:0] DEFAULT_DELIM = 8'h0A;

endpackage

// File: rtl/uart_packet_bridge_pkt_fifo.sv
// Packet-aware FIFO: entries are {end_flag, data}; tracks level, closed packets and the open tail.
// Full-flush closes a packet on the write that fills the FIFO; retro_close flags the newest entry.
module pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_delim,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_end,
  input  logic                       pkt_done,
  input  logic                       retro_close,
  output logic                       full,
  output logic                       has_open,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_last;
  logic [LW-1:0]   open_cnt;
  logic            wr_ok, rd_ok, wr_end, retro_ok, pkt_inc;

  assign full     = (level == LW'(DEPTH));
  assign has_open = (open_cnt != '0);
  assign wr_ok    = wr_en && !full;
  assign rd_ok    = rd_en && (level != '0);
  // The write that leaves the FIFO full closes the packet, so a full FIFO can always drain.
  assign wr_end   = wr_delim || ((level == LW'(DEPTH - 1)) && !rd_ok);
  assign retro_ok = retro_close && !wr_ok && has_open;
  assign pkt_inc  = (wr_ok && wr_end) || retro_ok;
  assign wr_last  = wr_ptr - AW'(1);

  // Storage array; a retro-close only sets the end flag of the newest entry.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {wr_end, wr_data};
    if (retro_ok) mem[wr_last][WIDTH] <= 1'b1;
  end

  // Pointers, registered read port and occupancy/packet counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_data   <= '0;
      rd_end    <= 1'b0;
      level     <= '0;
      pkt_count <= '0;
      open_cnt  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr][WIDTH-1:0];
        rd_end  <= mem[rd_ptr][WIDTH];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case ({pkt_inc, pkt_done})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
      if (wr_ok) open_cnt <= wr_end ? '0 : open_cnt + LW'(1);
      else if (retro_ok) open_cnt <= '0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, samples mid-bit, one-cycle o_RX_DV per good byte.
module UART_Rx #(
  parameter int FPGA_CLK_FREQ = 50000000,
  parameter int BAUDRATE      = 115200,
  parameter int WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_RX_Serial,
  output logic             o_RX_DV,
  output logic [WIDTH-1:0] o_RX_Byte
);

  localparam int CPB = FPGA_CLK_FREQ / BAUDRATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t        state, nxt;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic             dv_n;
  logic             rx_meta, rx_s;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= R_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      o_RX_DV <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      o_RX_DV <= dv_n;
    end
  end

  // Bit timing: confirm the start bit at half a bit, then sample each bit centre.
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n  = sh;
    dv_n  = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) nxt = R_START;
      end
      R_START: begin
        if (cnt == CW'((CPB - 1) / 2)) begin
          cnt_n = '0;
          nxt   = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[WIDTH-1:1]};
          if (idx == IW'(WIDTH - 1)) begin
            idx_n = '0;
            nxt   = R_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          nxt   = R_IDLE;
          dv_n  = rx_s;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

  assign o_RX_Byte = sh;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, stop bit; o_TX_Done pulses once the stop bit ends.
module UART_Tx #(
  parameter int FPGA_CLK_FREQ = 50000000,
  parameter int BAUDRATE      = 115200,
  parameter int WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_TX_DV,
  input  logic [WIDTH-1:0] i_TX_Byte,
  output logic             o_TX_Serial,
  output logic             o_TX_Done
);

  localparam int CPB = FPGA_CLK_FREQ / BAUDRATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_ser_state_t;

  tx_ser_state_t    state, nxt;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic             ser_n, done_n;

  // Serial output is registered and resets high so an aborted byte releases the line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= T_IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      o_TX_Serial <= ser_n;
      o_TX_Done   <= done_n;
    end
  end

  // Bit sequencing; the line level is chosen from the state being entered.
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    idx_n  = idx;
    sh_n   = sh;
    done_n = 1'b0;
    case (state)
      T_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (i_TX_DV) begin
          sh_n = i_TX_Byte;
          nxt  = T_START;
        end
      end
      T_START: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          nxt   = T_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      T_DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          if (idx == IW'(WIDTH - 1)) begin
            idx_n = '0;
            nxt   = T_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n  = '0;
          nxt    = T_IDLE;
          done_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
    case (nxt)
      T_START: ser_n = 1'b0;
      T_DATA:  ser_n = sh_n[idx_n];
      default: ser_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_packet_bridge.sv
// Store-and-forward UART bridge (watch RX -> ESP32 TX) forwarding only complete packets.
// Optional build macro: UART_BRIDGE_TIMEOUT_EN closes a partial packet after an idle timeout.
module uart_packet_bridge
  import uart_bridge_pkg::*;
#(
  parameter int               FPGA_CLK_FREQ = 50000000,
  parameter int               BAUDRATE      = 115200,
  parameter int               WIDTH         = 8,
  parameter int               DEPTH         = 16,
  parameter logic [WIDTH-1:0] DELIM         = WIDTH'(DEFAULT_DELIM),
  parameter int               TIMEOUT_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_rx_serial,
  input  logic                       i_tx_hold,
  input  logic                       i_clr_status,
  output logic                       o_tx_line,
  output logic                       o_tx_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_pkt_count,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow,
  output logic [DROP_CNT_W-1:0]      o_drop_count
);

  tx_state_t        state, nxt;
  logic             rx_dv, tx_dv, tx_done, rd_en, rd_end, pkt_done, retro;
  logic             full, has_open, drop;
  logic             end_q, end_n, done_q, done_n;
  logic [WIDTH-1:0] rx_byte, rd_data;

  UART_Rx #(.FPGA_CLK_FREQ(FPGA_CLK_FREQ), .BAUDRATE(BAUDRATE), .WIDTH(WIDTH)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_RX_Serial (i_rx_serial),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte)
  );

  pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (rx_dv),
    .wr_data     (rx_byte),
    .wr_delim    (rx_byte == DELIM),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_end      (rd_end),
    .pkt_done    (pkt_done),
    .retro_close (retro),
    .full        (full),
    .has_open    (has_open),
    .level       (o_level),
    .pkt_count   (o_pkt_count)
  );

  UART_Tx #(.FPGA_CLK_FREQ(FPGA_CLK_FREQ), .BAUDRATE(BAUDRATE), .WIDTH(WIDTH)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_TX_DV     (tx_dv),
    .i_TX_Byte   (rd_data),
    .o_TX_Serial (o_tx_line),
    .o_TX_Done   (tx_done)
  );

  // TX FSM state plus the latched end flag and "byte finished" memory for the hold case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      end_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      end_q  <= end_n;
      done_q <= done_n;
    end
  end

  // TX sequencing: hold is sampled only between bytes. done_q remembers a finished byte
  // while hold keeps the FSM in WAIT, since o_TX_Done is a single-cycle pulse.
  always_comb begin
    nxt      = state;
    rd_en    = 1'b0;
    tx_dv    = 1'b0;
    pkt_done = 1'b0;
    end_n    = end_q;
    done_n   = done_q;
    case (state)
      IDLE: begin
        done_n = 1'b0;
        if ((o_pkt_count != '0) && !i_tx_hold) nxt = LOAD;
      end
      LOAD: begin
        rd_en = 1'b1;
        nxt   = SEND;
      end
      SEND: begin
        tx_dv  = 1'b1;
        end_n  = rd_end;
        done_n = 1'b0;
        nxt    = WAIT;
      end
      default: begin
        if (tx_done || done_q) begin
          done_n = 1'b1;
          if (end_q) begin
            pkt_done = 1'b1;
            done_n   = 1'b0;
            nxt      = IDLE;
          end else if (!i_tx_hold) begin
            done_n = 1'b0;
            nxt    = LOAD;
          end
        end
      end
    endcase
  end

  assign o_tx_busy = (state != IDLE);
  assign drop      = rx_dv && full;

  // Sticky overflow flag and saturating drop counter; a clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (i_clr_status) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != '1) o_drop_count <= o_drop_count + DROP_CNT_W'(1);
    end
  end

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BYTES * (FPGA_CLK_FREQ / BAUDRATE) * 10;
  localparam int TW        = $clog2(TO_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  // Idle timer: runs only while a partial packet is open, restarts on every received byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (rx_dv || !has_open || (idle_cnt == TW'(TO_CYCLES - 1))) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign retro = has_open && !rx_dv && (idle_cnt == TW'(TO_CYCLES - 1));
`else
  // No timeout: the retro-close term is constant zero for any non-negative TIMEOUT_BYTES.
  assign retro = has_open && (TIMEOUT_BYTES < 0);
`endif

endmodule

// File: tb/tb_uart_packet_bridge.sv
// Self-checking bench for uart_packet_bridge: serial driver, serial decoder with an expected
// byte queue, a queue-based packet model, directed scenarios and randomized packet rounds.
module tb_uart_packet_bridge;

  localparam int CLK_HZ = 8000000;
  localparam int BAUD   = 1000000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int BYTE_T = CPB * 10;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam logic [7:0] DELIM = 8'h0A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial = 1'b1;
  logic          tx_hold = 1'b0;
  logic          clr_status = 1'b0;
  logic          tx_line, tx_busy, overflow;
  logic [LW-1:0] pkt_count, level;
  logic [7:0]    drop_count;

  uart_packet_bridge #(
    .FPGA_CLK_FREQ (CLK_HZ),
    .BAUDRATE      (BAUD),
    .WIDTH         (8),
    .DEPTH         (DEPTH),
    .DELIM         (DELIM),
    .TIMEOUT_BYTES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_serial  (rx_serial),
    .i_tx_hold    (tx_hold),
    .i_clr_status (clr_status),
    .o_tx_line    (tx_line),
    .o_tx_busy    (tx_busy),
    .o_pkt_count  (pkt_count),
    .o_level      (level),
    .o_overflow   (overflow),
    .o_drop_count (drop_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int         vectors = 0;
  int         miscompares = 0;
  int         tx_seen = 0;
  logic [7:0] exp_q[$];
  logic [8:0] model_q[$];
  int         m_pkt = 0;
  int         m_drops = 0;
  int         m_ovf = 0;

  function automatic void check(string name, int actual, int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  // Byte arrival as seen by the packet rules: drop when full, close on DELIM or on filling.
  function automatic void model_rx(logic [7:0] b);
    bit e;
    if (model_q.size() == DEPTH) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end else begin
      e = (b == DELIM) || (model_q.size() + 1 == DEPTH);
      model_q.push_back({e, b});
      if (e) m_pkt++;
    end
  endfunction

  // Timeout close: the newest open byte becomes the end of a packet.
  function automatic void model_timeout();
    if (model_q.size() > 0 && !model_q[model_q.size()-1][8]) begin
      model_q[model_q.size()-1][8] = 1'b1;
      m_pkt++;
    end
  endfunction

  // Everything up to the last closed entry will be forwarded, in order.
  function automatic void model_release();
    int last = -1;
    logic [8:0] e;
    for (int i = 0; i < model_q.size(); i++) if (model_q[i][8]) last = i;
    for (int i = 0; i <= last; i++) begin
      e = model_q.pop_front();
      exp_q.push_back(e[7:0]);
    end
    m_pkt = 0;
  endfunction

  function automatic void model_clear();
    model_q.delete();
    exp_q.delete();
    m_pkt = 0;
    m_drops = 0;
    m_ovf = 0;
  endfunction

  function automatic void check_status(string tag);
    check({tag, "_level"}, int'(level), model_q.size());
    check({tag, "_pkt_count"}, int'(pkt_count), m_pkt);
    check({tag, "_overflow"}, int'(overflow), m_ovf);
    check({tag, "_drop_count"}, int'(drop_count), m_drops);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_and_check(input logic [7:0] b, input string tag);
    send_byte(b);
    repeat (4) @(negedge clk);
    model_rx(b);
    check_status(tag);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_status = 1'b1;
    @(negedge clk) clr_status = 1'b0;
    m_ovf = 0;
    m_drops = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk) tx_hold = 1'b0;
    while (!(exp_q.size() == 0 && !tx_busy) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain_timeout: %0d bytes still expected, busy=%0d", tag, exp_q.size(), tx_busy);
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- serial decoder + per-cycle line check ----------------
  initial begin
    logic [7:0] b;
    logic       start_bit, stop_bit;
    bit         aborted;
    forever begin
      @(negedge tx_line);
      aborted = 0;
      repeat (CPB / 2) @(negedge clk);
      start_bit = tx_line;
      if (rst) aborted = 1;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_line;
        if (rst) aborted = 1;
      end
      repeat (CPB) @(negedge clk);
      stop_bit = tx_line;
      if (rst) aborted = 1;
      if (!aborted) begin
        check("tx_start_bit", int'(start_bit), 0);
        check("tx_stop_bit", int'(stop_bit), 1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected_byte: got %02h, expected none", b);
        end else begin
          check("tx_byte", int'(b), int'(exp_q.pop_front()));
        end
        tx_seen++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !tx_busy) begin
      vectors++;
      if (tx_line !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_line: got %b, expected 1 while not busy", tx_line);
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: bench exceeded cycle budget, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         t0, n, wait_n;
    bit         busy_seen;
    logic [7:0] b;

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_tx_line", int'(tx_line), 1);
    check("rst_tx_busy", int'(tx_busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_status("post_rst");

    // 1: simple packet 41 42 0A.
    tx_hold = 1'b1;
    send_and_check(8'h41, "t1_a");
    send_and_check(8'h42, "t1_b");
    send_and_check(8'h0A, "t1_c");
    check("t1_pkt_literal", int'(pkt_count), 1);
    model_release();
    drain("t1");
    check_status("t1_done");
    check("t1_line_idle", int'(tx_line), 1);

`ifndef UART_BRIDGE_TIMEOUT_EN
    // 2: unterminated packet stays put.
    tx_hold = 1'b0;
    send_and_check(8'h41, "t2_a");
    send_and_check(8'h42, "t2_b");
    busy_seen = 0;
    repeat (20 * BYTE_T) begin
      @(negedge clk);
      if (tx_busy) busy_seen = 1;
    end
    check("t2_no_tx_start", int'(busy_seen), 0);
    check("t2_level_literal", int'(level), 2);
    check("t2_pkt_literal", int'(pkt_count), 0);
    do_reset();
`endif

    // 3: overflow with hold, full-flush, release, clear.
    tx_hold = 1'b1;
    for (int i = 1; i <= 6; i++) send_and_check(8'(i), "t3_fill");
    check("t3_overflow_literal", int'(overflow), 1);
    check("t3_drops_literal", int'(drop_count), 2);
    check("t3_pkt_literal", int'(pkt_count), 1);
    check("t3_level_literal", int'(level), 4);
    model_release();
    drain("t3");
    check_status("t3_drained");
    pulse_clr();
    check("t3_clr_overflow", int'(overflow), 0);
    check("t3_clr_drops", int'(drop_count), 0);

    // 4: two back-to-back packets, hold raised mid-byte.
    tx_hold = 1'b1;
    send_and_check(8'h31, "t4");
    send_and_check(8'h0A, "t4");
    send_and_check(8'h32, "t4");
    send_and_check(8'h0A, "t4");
    check("t4_pkt_peak_literal", int'(pkt_count), 2);
    model_release();
    t0 = tx_seen;
    @(negedge clk) tx_hold = 1'b0;
    wait_n = 0;
    while (!tx_busy && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check("t4_tx_started", int'(tx_busy), 1);
    repeat (3 * CPB) @(negedge clk);
    tx_hold = 1'b1;
    repeat (3 * BYTE_T) @(negedge clk);
    check("t4_one_byte_sent", tx_seen - t0, 1);
    check("t4_held_level", int'(level), 3);
    check("t4_held_pkt", int'(pkt_count), 2);
    check("t4_held_busy", int'(tx_busy), 1);
    drain("t4");
    check("t4_all_sent", tx_seen - t0, 4);
    check_status("t4_done");

    // 5: reset during the second TX byte.
    tx_hold = 1'b0;
    send_and_check(8'h41, "t5");
    send_and_check(8'h42, "t5");
    send_and_check(8'h43, "t5");
    t0 = tx_seen;
    send_byte(8'h0A);
    model_rx(8'h0A);
    model_release();
    wait_n = 0;
    while (tx_seen == t0 && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    check("t5_first_byte_seen", tx_seen - t0, 1);
    repeat (3 * CPB) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_line_high", int'(tx_line), 1);
    check("t5_rst_busy", int'(tx_busy), 0);
    check("t5_rst_level", int'(level), 0);
    check("t5_rst_pkt", int'(pkt_count), 0);
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tx_hold = 1'b1;
    send_and_check(8'h61, "t5_after");
    send_and_check(8'h0A, "t5_after");
    model_release();
    t0 = tx_seen;
    drain("t5");
    check("t5_after_sent", tx_seen - t0, 2);
    check_status("t5_done");

`ifdef UART_BRIDGE_TIMEOUT_EN
    // 6: partial packet force-closed by the idle timeout.
    tx_hold = 1'b1;
    send_and_check(8'h55, "t6");
    repeat (9 * BYTE_T) @(negedge clk);
    model_timeout();
    check("t6_pkt_literal", int'(pkt_count), 1);
    check_status("t6_closed");
    model_release();
    t0 = tx_seen;
    drain("t6");
    check("t6_sent", tx_seen - t0, 1);
`endif

    // Randomized packet rounds.
    for (int r = 0; r < 20; r++) begin
      tx_hold = 1'b1;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        b = ($urandom_range(0, 3) == 0) ? DELIM : 8'($urandom_range(0, 255));
        send_and_check(b, "rnd_fill");
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        check_status("rnd_clr");
      end
`ifdef UART_BRIDGE_TIMEOUT_EN
      repeat (9 * BYTE_T) @(negedge clk);
      model_timeout();
      check_status("rnd_timeout");
`endif
      model_release();
      drain("rnd");
      check_status("rnd_drained");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
